flag_write_controller: RTL
==========================

Name: flag_write_controller

Overview:
- Sequences writes to the flags register (O, S, C, Z) and evaluates branch conditions against the stored flags.
- Accepts an ALU-op issue carrying a flag-update class, waits for the ALU result latency, then drives the 3-bit W_RF write-select for exactly one cycle.
- Serialises condition evaluation against pending flag writes, so a branch always sees the flags of all previously issued ops.
- Sits between the control unit and register_flags.

Parameters:
ALU_LAT, 1, cycles from op acceptance to ALU flag outputs valid; legal range 1..7.

Ports:
CLK  input  1  system clock, all logic on posedge
RST  input  1  synchronous reset, active-high
op_valid  input  1  ALU op issue request
op_class  input  3  flag-update class, same encoding as W_RF: 000 none, 001 Z, 010 SZ, 011 SCZ, 100 OSCZ; 101..111 treated as 000
op_ready  output  1  op accept, 1 only in IDLE
cond_valid  input  1  condition evaluation request
cond_code  input  4  condition selector (see Behaviour)
cond_ready  output  1  condition accept
flag_O, flag_S, flag_C, flag_Z  input  1 each  stored flag outputs of the flags register
W_RF  output  3  registered write-select to the flags register
cond_done  output  1  one-cycle pulse, result valid
cond_taken  output  1  condition result, held until next cond_done
busy  output  1  1 when state is not IDLE

Behaviour:
- Reset (RST=1 at posedge):
  - state=IDLE, W_RF=000, cond_done=0, cond_taken=0, wait counter=0, captured class=000.
  - RST overrides all inputs.
  - Reset during WAIT or WRITE aborts the pending write; no W_RF pulse follows.
- States:
  - IDLE: op_ready=1. cond_ready=~op_valid, so an op has priority over a same-cycle condition.
  - Op accepted with class 000 or invalid: no state change, no W_RF pulse; op_ready stays 1.
  - Op accepted with a valid nonzero class: capture class. If ALU_LAT=1, go to WRITE; else load counter=ALU_LAT-1 and go to WAIT.
  - WAIT: decrement counter each cycle. When counter reaches 1, go to WRITE on the next edge. op_ready=0, cond_ready=0.
  - WRITE: W_RF=captured class for exactly this cycle; register_flags samples at the closing edge. Next state is IDLE. op_ready=0, cond_ready=0.
- Timing:
  - Op accepted in cycle T, so W_RF is nonzero in cycle T+ALU_LAT only.
  - W_RF=000 in every other cycle.
  - Next op acceptance is possible at T+ALU_LAT+1, giving one op per ALU_LAT+1 cycles.
- Condition evaluation:
  - Accepted in IDLE when cond_valid & cond_ready at cycle T. The result is computed from flag_* sampled at T.
  - cond_done=1 in T+1 with cond_taken updated. Back-to-back acceptance is allowed, one per cycle.
  - Flags written at the end of WRITE are visible to any condition accepted in the following IDLE cycle or later.
- cond_code map:
  - 0 always, 1 Z, 2 ~Z, 3 S, 4 ~S, 5 C, 6 ~C, 7 O, 8 ~O
  - 9 S^O (signed less), 10 ~(S^O), 11 (S^O)|Z, 12 ~((S^O)|Z)
  - 13..15 never (cond_taken=0, cond_done still pulses).
- cond_done is 0 in any cycle with no accepted condition in the prior cycle. cond_taken holds its previous value.
- busy equals (state != IDLE).

Test Plan:
- Reset: hold RST 2 cycles with op_valid=1, cond_valid=1 -> W_RF=000, cond_done=0, cond_taken=0, busy=0, op_ready=1.
- ALU_LAT=3, op_class=011 accepted at cycle 10 -> W_RF=011 only at cycle 13; op_ready=0 in cycles 11..13, 1 at 14; busy=1 in cycles 11..13.
- ALU_LAT=1, op_class=100 accepted at cycle 5 -> W_RF=100 at cycle 6, idle at 7. Then op_class=110 accepted at cycle 7 -> no W_RF pulse, op_ready stays 1.
- Ordering: flags Z=0 held, op_class=001 with ALU Z=1 issued; cond_code=1 requested continuously -> cond_ready=0 until the post-WRITE IDLE cycle; the accepted cond yields cond_taken=1 with cond_done one cycle later.
- Codes: S=1, O=0, Z=0 -> conditions 9,10,11,12,13 give taken 1,0,1,0,0 on consecutive cond_done pulses issued back-to-back.
- Reset mid-WAIT: ALU_LAT=4, op accepted at cycle 20, RST=1 at cycle 22 -> no W_RF pulse in cycles 22..30, state IDLE at 23.

Source files
------------

// File: rtl/flag_write_controller.sv
// Flag write sequencer: accepts an ALU op carrying a flag-update class,
// waits out the ALU latency, then pulses W_RF for one cycle so that
// register_flags captures the new flags. Condition evaluation is only
// accepted in IDLE, so a branch never sees stale flags from an in-flight op.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready
// are both 1. op_ready depends only on state. cond_ready also depends on
// op_valid, so an op wins over a condition offered in the same cycle.
module flag_write_controller #(
   parameter int ALU_LAT = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       op_valid,
   input  logic [2:0] op_class,
   output logic       op_ready,
   input  logic       cond_valid,
   input  logic [3:0] cond_code,
   output logic       cond_ready,
   input  logic       flag_O,
   input  logic       flag_S,
   input  logic       flag_C,
   input  logic       flag_Z,
   output logic [2:0] W_RF,
   output logic       cond_done,
   output logic       cond_taken,
   output logic       busy,
   output logic [1:0] o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   // Counter start value: WAIT lasts ALU_LAT-1 cycles before WRITE.
   localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

   state_t     r_state;
   logic [2:0] r_cnt;
   logic [2:0] r_class;
   logic [2:0] r_w_rf;
   logic       r_cond_done;
   logic       r_cond_taken;

   logic       w_idle;
   logic       w_op_acc;
   logic       w_class_ok;
   logic       w_cond_acc;
   logic       w_taken;
   logic       w_slt;

   assign w_idle     = (r_state == S_IDLE);
   assign w_op_acc   = w_idle & op_valid;
   // Only 001..100 request a write; 000 and 101..111 are accepted and dropped.
   assign w_class_ok = (op_class != 3'd0) && (op_class <= 3'd4);
   assign w_cond_acc = w_idle & cond_valid & ~op_valid;
   assign w_slt      = flag_S ^ flag_O;

   assign op_ready    = w_idle;
   assign cond_ready  = w_idle & ~op_valid;
   assign busy        = ~w_idle;
   assign W_RF        = r_w_rf;
   assign cond_done   = r_cond_done;
   assign cond_taken  = r_cond_taken;
   assign o_dbg_state = r_state;

   // Condition decode from the flags as they stand in the accepting cycle.
   always_comb begin
      w_taken = 1'b0;
      case (cond_code)
         4'd0:    w_taken = 1'b1;
         4'd1:    w_taken = flag_Z;
         4'd2:    w_taken = ~flag_Z;
         4'd3:    w_taken = flag_S;
         4'd4:    w_taken = ~flag_S;
         4'd5:    w_taken = flag_C;
         4'd6:    w_taken = ~flag_C;
         4'd7:    w_taken = flag_O;
         4'd8:    w_taken = ~flag_O;
         4'd9:    w_taken = w_slt;
         4'd10:   w_taken = ~w_slt;
         4'd11:   w_taken = w_slt | flag_Z;
         4'd12:   w_taken = ~(w_slt | flag_Z);
         default: w_taken = 1'b0;
      endcase
   end

   // Sequencer FSM with registered W_RF pulse and condition result.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_cnt        <= 3'd0;
         r_class      <= 3'd0;
         r_w_rf       <= 3'd0;
         r_cond_done  <= 1'b0;
         r_cond_taken <= 1'b0;
      end else begin
         r_cond_done <= w_cond_acc;
         if (w_cond_acc) begin
            r_cond_taken <= w_taken;
         end
         // W_RF is nonzero only in the cycle immediately after this default.
         r_w_rf <= 3'd0;
         case (r_state)
            S_IDLE: begin
               if (w_op_acc && w_class_ok) begin
                  r_class <= op_class;
                  if (ALU_LAT == 1) begin
                     r_state <= S_WRITE;
                     r_w_rf  <= op_class;
                  end else begin
                     r_cnt   <= LAT_M1;
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  r_state <= S_WRITE;
                  r_w_rf  <= r_class;
               end
            end
            S_WRITE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
